// File: rtl/rf_mp.sv
// rf_mp: parametrised multi-port register file.
//   One synchronous write port and R independent registered read ports.
//   Each register has a valid bit that is set on write and cleared by reset
//   or by clr. A read of the address being written on the same edge returns
//   the new data (bypass). clr has priority over write and over reads.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous reset, active low
//   clr    - synchronous clear of all registers and valid bits
//   write  - write enable
//   waddr  - write address (M bits)
//   wd     - write data (N bits)
//   read   - per-port read enable (bit i -> port i)
//   ra     - read addresses, port i at ra[i*M +: M]
//   q      - registered read data, port i at q[i*N +: N]
//   qv     - registered valid flag per port
//
// Build option: define RF_ZERO_REG_EN to hardwire address 0 to zero
// (writes ignored, reads return q=0/qv=1, no storage for address 0).

module rf_mp #(
  parameter int unsigned M = 3,
  parameter int unsigned N = 8,
  parameter int unsigned R = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           write,
  input  logic [M-1:0]   waddr,
  input  logic [N-1:0]   wd,
  input  logic [R-1:0]   read,
  input  logic [R*M-1:0] ra,
  output logic [R*N-1:0] q,
  output logic [R-1:0]   qv
);

  localparam int unsigned DEPTH = 1 << M;
`ifdef RF_ZERO_REG_EN
  localparam bit          ZERO_EN = 1'b1;
  localparam int unsigned LO      = 1;
`else
  localparam bit          ZERO_EN = 1'b0;
  localparam int unsigned LO      = 0;
`endif

  logic [N-1:0]     r_mem [LO:DEPTH-1];
  logic [DEPTH-1:LO] r_valid;
  logic [R*N-1:0]   r_q;
  logic [R-1:0]     r_qv;

  logic             w_wr_en;
  logic [M-1:0]     w_ra;
  logic [R*N-1:0]   w_q_nxt;
  logic [R-1:0]     w_qv_nxt;

  // Writes to the hardwired zero register are dropped entirely.
  assign w_wr_en = write && !(ZERO_EN && (waddr == '0));

  // Next read value per port; the zero-register check precedes the bypass
  // so address 0 can never pick up in-flight write data.
  always_comb begin
    w_q_nxt  = '0;
    w_qv_nxt = '0;
    w_ra     = '0;
    for (int unsigned p = 0; p < R; p++) begin
      w_ra = ra[p*M +: M];
      if (!clr) begin
        if (ZERO_EN && (w_ra == '0)) begin
          w_qv_nxt[p] = 1'b1;
        end else if (write && (waddr == w_ra)) begin
          w_q_nxt[p*N +: N] = wd;
          w_qv_nxt[p]       = 1'b1;
        end else begin
          for (int unsigned a = LO; a < DEPTH; a++) begin
            if (w_ra == M'(a)) begin
              w_q_nxt[p*N +: N] = r_mem[a];
              w_qv_nxt[p]       = r_valid[a];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned a = LO; a < DEPTH; a++) r_mem[a] <= '0;
      r_valid <= '0;
    end else if (clr) begin
      for (int unsigned a = LO; a < DEPTH; a++) r_mem[a] <= '0;
      r_valid <= '0;
    end else if (w_wr_en) begin
      for (int unsigned a = LO; a < DEPTH; a++) begin
        if (waddr == M'(a)) begin
          r_mem[a]   <= wd;
          r_valid[a] <= 1'b1;
        end
      end
    end
  end

  // Ports with read=0 hold, even across a clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q  <= '0;
      r_qv <= '0;
    end else begin
      for (int unsigned p = 0; p < R; p++) begin
        if (read[p]) begin
          r_q[p*N +: N] <= w_q_nxt[p*N +: N];
          r_qv[p]       <= w_qv_nxt[p];
        end
      end
    end
  end

  assign q  = r_q;
  assign qv = r_qv;

endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed bench for rf_mp (M=3, N=8, R=2) with a behavioural
// reference model compared on every clock, plus literal expectations.

module tb_rf_mp;

  localparam int unsigned M = 3;
  localparam int unsigned N = 8;
  localparam int unsigned R = 2;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic           clk   = 1'b0;
  logic           rst   = 1'b0;
  logic           clr   = 1'b0;
  logic           write = 1'b0;
  logic [M-1:0]   waddr = '0;
  logic [N-1:0]   wd    = '0;
  logic [R-1:0]   read  = '0;
  logic [R*M-1:0] ra    = '0;
  logic [R*N-1:0] q;
  logic [R-1:0]   qv;

  int tests = 0;
  int fails = 0;
  bit model_on = 1'b0;

  rf_mp #(.M(M), .N(N), .R(R)) dut (
    .clk(clk), .rst(rst), .clr(clr), .write(write), .waddr(waddr),
    .wd(wd), .read(read), .ra(ra), .q(q), .qv(qv)
  );

  always #5 clk = ~clk;

  // Reference state: register contents, written flags, expected outputs.
  logic [N-1:0] m_mem [8];
  bit           m_val [8];
  logic [N-1:0] e_q   [R];
  bit           e_v   [R];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    for (int p = 0; p < R; p++) begin
      e_q[p] = '0;
      e_v[p] = 1'b0;
    end
  endtask

  always @(negedge rst) model_reset();

  // Reads see storage as it was before this edge; then the write/clear lands.
  always @(posedge clk) begin
    if (model_on && rst) begin
      for (int p = 0; p < R; p++) begin
        if (read[p]) begin
          int a;
          a = int'(ra[p*M +: M]);
          if (clr)                            begin e_q[p] = '0;       e_v[p] = 1'b0;     end
          else if (ZERO && a == 0)            begin e_q[p] = '0;       e_v[p] = 1'b1;     end
          else if (write && int'(waddr) == a) begin e_q[p] = wd;       e_v[p] = 1'b1;     end
          else                                begin e_q[p] = m_mem[a]; e_v[p] = m_val[a]; end
        end
      end
      if (clr) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[i] = '0;
          m_val[i] = 1'b0;
        end
      end else if (write && !(ZERO && waddr == '0)) begin
        m_mem[waddr] = wd;
        m_val[waddr] = 1'b1;
      end
      #2;
      for (int p = 0; p < R; p++) begin
        check($sformatf("model_q%0d", p), 32'(q[p*N +: N]), 32'(e_q[p]));
        check($sformatf("model_qv%0d", p), 32'(qv[p]), 32'(e_v[p]));
      end
    end
  end

  // Apply one cycle of inputs at a falling edge and wait for the next one.
  task automatic step(input logic c, input logic w, input logic [M-1:0] wa,
                      input logic [N-1:0] d, input logic [R-1:0] rd,
                      input logic [M-1:0] a0, input logic [M-1:0] a1);
    clr   = c;
    write = w;
    waddr = wa;
    wd    = d;
    read  = rd;
    ra    = {a1, a0};
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_on = 1'b1;
    check("reset_q", 32'(q), 32'h0);
    check("reset_qv", 32'(qv), 32'h0);

    // unwritten register
    step(0, 0, 0, 8'h00, 2'b01, 3'd5, 3'd0);
    check("unwritten_q0", 32'(q[7:0]), 32'h00);
    check("unwritten_qv0", 32'(qv[0]), 32'h0);

    // write then read on both ports, then hold
    step(0, 1, 3'd2, 8'h3C, 2'b00, 3'd0, 3'd0);
    step(0, 0, 3'd0, 8'h00, 2'b11, 3'd2, 3'd2);
    check("wr_rd_q", 32'(q), 32'h3C3C);
    check("wr_rd_qv", 32'(qv), 32'h3);
    step(0, 0, 3'd0, 8'h00, 2'b00, 3'd7, 3'd7);
    check("hold_q", 32'(q), 32'h3C3C);
    check("hold_qv", 32'(qv), 32'h3);

    // bypass on port1
    step(0, 1, 3'd6, 8'h11, 2'b00, 3'd0, 3'd0);
    step(0, 1, 3'd6, 8'hA5, 2'b10, 3'd0, 3'd6);
    check("bypass_q", 32'(q), 32'hA53C);
    check("bypass_qv", 32'(qv), 32'h3);

    // clear beats write and read; port1 holds
    step(0, 1, 3'd3, 8'h55, 2'b00, 3'd0, 3'd0);
    step(1, 1, 3'd3, 8'h77, 2'b01, 3'd3, 3'd0);
    check("clr_q", 32'(q), 32'hA500);
    check("clr_qv", 32'(qv), 32'h2);
    step(0, 0, 3'd0, 8'h00, 2'b11, 3'd3, 3'd6);
    check("after_clr_q", 32'(q), 32'h0000);
    check("after_clr_qv", 32'(qv), 32'h0);

    // fill all addresses and read them back in pairs
    for (int a = 0; a < 8; a++) step(0, 1, 3'(a), 8'(a), 2'b00, 3'd0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 3'd0, 8'h00, 2'b11, 3'(2*k), 3'(2*k+1));
      check($sformatf("pair%0d_q", k), 32'(q), {16'h0, 8'(2*k+1), 8'(2*k)});
      check($sformatf("pair%0d_qv", k), 32'(qv), 32'h3);
    end

    // back-to-back writes, second read bypasses
    step(0, 1, 3'd7, 8'h21, 2'b00, 3'd0, 3'd0);
    step(0, 1, 3'd7, 8'h42, 2'b01, 3'd7, 3'd0);
    check("b2b_bypass_q0", 32'(q[7:0]), 32'h42);
    step(0, 0, 3'd0, 8'h00, 2'b11, 3'd7, 3'd7);
    check("b2b_stored_q", 32'(q), 32'h4242);

    // asynchronous reset mid-cycle with a write in flight
    clr = 0; write = 1; waddr = 3'd4; wd = 8'h99; read = 2'b00;
    #3 rst = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_qv", 32'(qv), 32'h0);
    @(negedge clk);
    write = 0;
    rst = 1'b1;
    step(0, 0, 3'd0, 8'h00, 2'b11, 3'd4, 3'd1);
    check("post_rst_q", 32'(q), 32'h0);
    check("post_rst_qv", 32'(qv), 32'h0);

`ifdef RF_ZERO_REG_EN
    step(0, 1, 3'd0, 8'hFF, 2'b00, 3'd0, 3'd0);
    step(0, 0, 3'd0, 8'h00, 2'b01, 3'd0, 3'd0);
    check("zero_rd_q0", 32'(q[7:0]), 32'h00);
    check("zero_rd_qv0", 32'(qv[0]), 32'h1);
    step(0, 1, 3'd0, 8'hEE, 2'b10, 3'd0, 3'd0);
    check("zero_byp_q1", 32'(q[15:8]), 32'h00);
    check("zero_byp_qv1", 32'(qv[1]), 32'h1);
`endif

    model_on = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
